fifo_mem_ctrl: RTL and testbench

Pointer/flag controller that sequences one mem_param instance as a synchronous first-word-fall-through FIFO. It accepts push/pop requests and generates the write enable, write address and read address for the memory. It also maintains occupancy, full/empty and almost-full/almost-empty status. Data does not pass through this block: the wrapper connects wdata/rdata straight to the memory.

---
 rtl/fifo_mem_ctrl.sv | 95 +++++++++
 tb/tb_fifo_mem_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_mem_ctrl.sv
`default_nettype none
// ============================================================================
// fifo_mem_ctrl : pointer/flag controller driving a mem_param as an FWFT FIFO.
// Optional sticky ovf/udf error outputs when FIFO_ERR_FLAGS_EN is defined.
// Revision: 1.0
// ============================================================================
module fifo_mem_ctrl #(
   parameter int DEPTH      = 8,
   parameter int AFULL_LVL  = 2**DEPTH - 4,
   parameter int AEMPTY_LVL = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   output logic             mem_write,
   output logic [DEPTH-1:0] mem_waddr,
   output logic [DEPTH-1:0] mem_raddr,
   output logic [DEPTH:0]   count,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty
`ifdef FIFO_ERR_FLAGS_EN
   ,
   output logic             ovf,
   output logic             udf
`endif
);

   localparam logic [DEPTH:0] c_CAP = {1'b1, {DEPTH{1'b0}}};
   localparam logic [DEPTH:0] c_ONE = {{DEPTH{1'b0}}, 1'b1};

   logic [DEPTH:0] r_wr_ptr;
   logic [DEPTH:0] r_rd_ptr;
   logic [DEPTH:0] r_count;
   logic           w_push_acc;
   logic           w_pop_acc;

   // Flags come only from the count register, so request inputs never reach them.
   assign full         = (r_count == c_CAP);
   assign empty        = (r_count == '0);
   assign almost_full  = (int'(r_count) >= AFULL_LVL);
   assign almost_empty = (int'(r_count) <= AEMPTY_LVL);

   assign w_push_acc = push & ~full;
   assign w_pop_acc  = pop & ~empty;

   assign mem_write = w_push_acc;
   assign mem_waddr = r_wr_ptr[DEPTH-1:0];
   assign mem_raddr = r_rd_ptr[DEPTH-1:0];
   assign count     = r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_acc) r_wr_ptr <= r_wr_ptr + c_ONE;
         if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + c_ONE;
         case ({w_push_acc, w_pop_acc})
            2'b10:   r_count <= r_count + c_ONE;
            2'b01:   r_count <= r_count - c_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef FIFO_ERR_FLAGS_EN
   logic r_ovf;
   logic r_udf;

   // A new offence in the flush cycle still leaves the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         r_ovf <= (r_ovf & ~flush) | (push & full);
         r_udf <= (r_udf & ~flush) | (pop & empty);
      end
   end

   assign ovf = r_ovf;
   assign udf = r_udf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_mem_ctrl.sv
`default_nettype none
// Testbench for fifo_mem_ctrl (DEPTH=2): directed stimulus, per-cycle model compare.
module tb_fifo_mem_ctrl;
   localparam int DEPTH = 2;
   localparam int CAP   = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       push, pop, flush;
   logic       mem_write;
   logic [1:0] mem_waddr, mem_raddr;
   logic [2:0] count;
   logic       full, empty, almost_full, almost_empty;
`ifdef FIFO_ERR_FLAGS_EN
   logic       ovf, udf;
`endif

   fifo_mem_ctrl #(.DEPTH(DEPTH), .AFULL_LVL(3), .AEMPTY_LVL(1)) dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush),
      .mem_write(mem_write), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
      .count(count), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty)
`ifdef FIFO_ERR_FLAGS_EN
      , .ovf(ovf), .udf(udf)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: totals of accepted pushes and pops since the last reset/flush.
   int m_wr, m_rd;
   bit m_ovf, m_udf;

   always @(posedge clk or posedge rst) begin
      int cnt;
      bit pa, qa;
      if (rst) begin
         m_wr = 0; m_rd = 0; m_ovf = 0; m_udf = 0;
      end else begin
         cnt = m_wr - m_rd;
         pa  = push && (cnt != CAP);
         qa  = pop && (cnt != 0);
         m_ovf = (m_ovf && !flush) || (push && cnt == CAP);
         m_udf = (m_udf && !flush) || (pop && cnt == 0);
         if (flush) begin
            m_wr = 0; m_rd = 0;
         end else begin
            m_wr += int'(pa);
            m_rd += int'(qa);
         end
      end
   end

   always @(negedge clk) begin
      int cnt;
      cnt = m_wr - m_rd;
      check("model_count",   32'(count),        32'(cnt));
      check("model_full",    32'(full),         32'(cnt == CAP));
      check("model_empty",   32'(empty),        32'(cnt == 0));
      check("model_afull",   32'(almost_full),  32'(cnt >= 3));
      check("model_aempty",  32'(almost_empty), 32'(cnt <= 1));
      check("model_write",   32'(mem_write),    32'(!rst && push && cnt != CAP));
      check("model_waddr",   32'(mem_waddr),    32'(m_wr % CAP));
      check("model_raddr",   32'(mem_raddr),    32'(m_rd % CAP));
`ifdef FIFO_ERR_FLAGS_EN
      check("model_ovf",     32'(ovf),          32'(m_ovf));
      check("model_udf",     32'(udf),          32'(m_udf));
`endif
   end

   task automatic drive(input logic p, input logic q, input logic f);
      push = p; pop = q; flush = f;
      #2;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] ra;
      rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // 1. async reset mid-cycle after some traffic
      drive(1, 0, 0); step();
      drive(1, 0, 0); step();
      drive(0, 1, 0); step();
      drive(0, 0, 0);
      check("pre_reset_raddr", 32'(mem_raddr), 32'd1);
      rst = 1'b1;
      #1;
      check("rst_count",  32'(count),        32'd0);
      check("rst_empty",  32'(empty),        32'd1);
      check("rst_aempty", 32'(almost_empty), 32'd1);
      check("rst_full",   32'(full),         32'd0);
      check("rst_afull",  32'(almost_full),  32'd0);
      check("rst_raddr",  32'(mem_raddr),    32'd0);
      step();
      rst = 1'b0;

      // 2. fill
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0);
         check("fill_write", 32'(mem_write), 32'd1);
         check("fill_waddr", 32'(mem_waddr), 32'(i));
         step();
         if (i == 2) begin
            check("fill3_count", 32'(count), 32'd3);
            check("fill3_afull", 32'(almost_full), 32'd1);
         end
      end
      check("fill4_full",  32'(full),  32'd1);
      check("fill4_count", 32'(count), 32'd4);
      drive(1, 0, 0);
      check("push_full_write", 32'(mem_write), 32'd0);
      step();
      check("push_full_count", 32'(count), 32'd4);
`ifdef FIFO_ERR_FLAGS_EN
      check("ovf_set", 32'(ovf), 32'd1);
`endif

      // 3. drain and wrap
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 0);
         check("drain_raddr", 32'(mem_raddr), 32'(i));
         step();
      end
      check("drain_empty", 32'(empty), 32'd1);
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, 0);
         check("wrap_waddr", 32'(mem_waddr), 32'(i));
         step();
      end
      for (int i = 0; i < 2; i++) begin
         drive(0, 1, 0);
         check("wrap_raddr", 32'(mem_raddr), 32'(i));
         step();
      end
      check("wrap_empty", 32'(empty), 32'd1);

      // 4. simultaneous push/pop
      drive(1, 0, 0); step();
      drive(1, 0, 0); step();
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 0);
         check("sim_raddr", 32'(mem_raddr), 32'((2 + i) % 4));
         step();
         check("sim_count", 32'(count), 32'd2);
      end
      drive(1, 0, 0); step();
      drive(1, 0, 0); step();
      drive(1, 1, 0);
      check("full_pp_write", 32'(mem_write), 32'd0);
      step();
      check("full_pp_count", 32'(count), 32'd3);
      for (int i = 0; i < 3; i++) begin drive(0, 1, 0); step(); end
      check("pre_pp_empty", 32'(empty), 32'd1);
      ra = mem_raddr;
      drive(1, 1, 0); step();
      check("empty_pp_count", 32'(count), 32'd1);
      check("empty_pp_raddr", 32'(mem_raddr), 32'(ra));

      // 5. flush with push
      drive(1, 0, 0); step();
      drive(1, 0, 0); step();
      check("pre_flush_count", 32'(count), 32'd3);
      drive(1, 0, 1); step();
      drive(0, 0, 0);
      check("flush_count", 32'(count),     32'd0);
      check("flush_empty", 32'(empty),     32'd1);
      check("flush_waddr", 32'(mem_waddr), 32'd0);
      check("flush_raddr", 32'(mem_raddr), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
      check("flush_ovf", 32'(ovf), 32'd0);
`endif

      // 6. underflow
      for (int i = 0; i < 2; i++) begin
         drive(0, 1, 0); step();
         check("udf_count", 32'(count),     32'd0);
         check("udf_raddr", 32'(mem_raddr), 32'd0);
      end
`ifdef FIFO_ERR_FLAGS_EN
      drive(0, 0, 0); step();
      check("udf_sticky", 32'(udf), 32'd1);
      drive(0, 0, 1); step();
      check("udf_cleared", 32'(udf), 32'd0);
`endif
      drive(0, 0, 0); step(); step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
